// File: rtl/butterfly_result_collector_pkg.sv
// Shared widths and FSM encoding for the butterfly result collector.
package butterfly_result_collector_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned LANE_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } brc_state_e;

endpackage

// File: rtl/butterfly_result_collector_lane_fifo.sv
// Per-lane synchronous FIFO; read data comes straight from the storage flops,
// so a word written on an edge is only poppable from the following cycle.
module brc_lane_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  always_comb begin
    o_full    = (r_count == (AW+1)'(DEPTH));
    o_empty   = (r_count == '0);
    w_do_push = i_push & ~o_full;
    w_do_pop  = i_pop & ~o_empty;
    o_rdata   = r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/butterfly_result_collector.sv
// Collects per-lane real/imag samples, realigns lanes through FIFOs and emits
// packed complex words with valid/ready/last, counting `length` beats per run.
module butterfly_result_collector
  import butterfly_result_collector_pkg::*;
#(
  parameter int unsigned data_width              = 16,
  parameter int unsigned parallelism_per_control = 4,
  parameter int unsigned fifo_depth              = 8
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [CNT_W-1:0]                               length,
  input  logic [parallelism_per_control-1:0]             in_vld_A,
  input  logic [data_width*parallelism_per_control-1:0]  in_dat_A,
  output logic                                           in_rdy_A,
  input  logic [parallelism_per_control-1:0]             in_vld_B,
  input  logic [data_width*parallelism_per_control-1:0]  in_dat_B,
  output logic                                           in_rdy_B,
  output logic                                           out_vld,
  output logic [2*data_width*parallelism_per_control-1:0] out_dat,
  output logic                                           out_last,
  input  logic                                           out_rdy,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           err_extra
);

  localparam int unsigned P  = parallelism_per_control;
  localparam int unsigned DW = data_width;

  brc_state_e r_state, w_state_nxt;

  logic [CNT_W-1:0]          r_len;
  logic [CNT_W-1:0]          r_out_cnt;
  logic [P-1:0][CNT_W-1:0]   r_acc_A, r_acc_B;
  logic [P-1:0][DW-1:0]      w_rd_A, w_rd_B;
  logic [P-1:0]              w_full_A, w_full_B, w_empty_A, w_empty_B;
  logic [P-1:0]              w_at_len_A, w_at_len_B;
  logic [P-1:0]              w_push_A, w_push_B, w_drop_A, w_drop_B;
  logic [2*DW*P-1:0]         w_pack;
  logic                      w_pop, w_out_hs, w_last_hs;

  always_comb begin
    w_pack = '0;
    for (int unsigned i = 0; i < P; i++) begin
      w_at_len_A[i] = (r_acc_A[i] == r_len);
      w_at_len_B[i] = (r_acc_B[i] == r_len);
      w_pack[2*DW*i +: 2*DW] = {w_rd_B[i], w_rd_A[i]};
    end
    in_rdy_A = (r_state == RUN) & ~(|w_full_A) & ~(&w_at_len_A);
    in_rdy_B = (r_state == RUN) & ~(|w_full_B) & ~(&w_at_len_B);
    // A lane already at length still handshakes, but its sample is discarded.
    w_push_A = in_vld_A & {P{in_rdy_A}} & ~w_at_len_A;
    w_push_B = in_vld_B & {P{in_rdy_B}} & ~w_at_len_B;
    w_drop_A = in_vld_A & {P{in_rdy_A}} & w_at_len_A;
    w_drop_B = in_vld_B & {P{in_rdy_B}} & w_at_len_B;
    w_pop     = ~(|w_empty_A) & ~(|w_empty_B) & (~out_vld | out_rdy);
    out_last  = out_vld & (r_out_cnt == r_len - CNT_W'(1));
    w_out_hs  = out_vld & out_rdy;
    w_last_hs = w_out_hs & out_last;
    busy      = (r_state == RUN);
    done      = (r_state == DONE);
  end

  for (genvar g = 0; g < P; g++) begin : g_lane
    brc_lane_fifo #(.WIDTH(DW), .DEPTH(fifo_depth)) u_fifo_a (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push_A[g]),
      .i_wdata (in_dat_A[DW*g +: DW]),
      .i_pop   (w_pop),
      .o_rdata (w_rd_A[g]),
      .o_full  (w_full_A[g]),
      .o_empty (w_empty_A[g])
    );
    brc_lane_fifo #(.WIDTH(DW), .DEPTH(fifo_depth)) u_fifo_b (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push_B[g]),
      .i_wdata (in_dat_B[DW*g +: DW]),
      .i_pop   (w_pop),
      .o_rdata (w_rd_B[g]),
      .o_full  (w_full_B[g]),
      .o_empty (w_empty_B[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = (length == '0) ? DONE : RUN;
      RUN:     if (w_last_hs) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len     <= '0;
      r_out_cnt <= '0;
      r_acc_A   <= '0;
      r_acc_B   <= '0;
      err_extra <= 1'b0;
      out_vld   <= 1'b0;
      out_dat   <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_len     <= length;
        r_out_cnt <= '0;
        r_acc_A   <= '0;
        r_acc_B   <= '0;
        err_extra <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < P; i++) begin
          if (w_push_A[i]) r_acc_A[i] <= r_acc_A[i] + CNT_W'(1);
          if (w_push_B[i]) r_acc_B[i] <= r_acc_B[i] + CNT_W'(1);
        end
        if (|w_drop_A || |w_drop_B) err_extra <= 1'b1;
        if (w_out_hs) r_out_cnt <= r_out_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        out_dat <= w_pack;
        out_vld <= 1'b1;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_butterfly_result_collector.sv
// Scoreboard bench: stimulus pushes expected packed beats, a negedge monitor pops and compares.
module tb_butterfly_result_collector;
  import butterfly_result_collector_pkg::*;

  localparam int P  = 4;
  localparam int DW = 16;
  localparam int OW = LANE_W * P;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   length;
  logic [P-1:0]  in_vld_A, in_vld_B;
  logic [DW*P-1:0] in_dat_A, in_dat_B;
  logic          in_rdy_A, in_rdy_B;
  logic          out_vld, out_last, out_rdy;
  logic [OW-1:0] out_dat;
  logic          busy, done, err_extra;

  butterfly_result_collector #(
    .data_width(DW), .parallelism_per_control(P), .fifo_depth(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .in_vld_A(in_vld_A), .in_dat_A(in_dat_A), .in_rdy_A(in_rdy_A),
    .in_vld_B(in_vld_B), .in_dat_B(in_dat_B), .in_rdy_B(in_rdy_B),
    .out_vld(out_vld), .out_dat(out_dat), .out_last(out_last), .out_rdy(out_rdy),
    .busy(busy), .done(done), .err_extra(err_extra)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] a_smp(int run, int lane, int k);
    return 16'(32'hA000 + run * 256 + lane * 16 + k);
  endfunction

  function automatic logic [15:0] b_smp(int run, int lane, int k);
    return 16'(32'hB000 + run * 256 + lane * 16 + k);
  endfunction

  function automatic logic [OW-1:0] exp_word(int run, int k);
    logic [OW-1:0] w;
    w = '0;
    for (int i = 0; i < P; i++) w[LANE_W*i +: LANE_W] = {b_smp(run, i, k), a_smp(run, i, k)};
    return w;
  endfunction

  typedef struct {
    logic [OW-1:0] dat;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;
  int   hs_cyc[$];
  int   cyc      = 0;
  int   done_cnt = 0;
  logic [OW-1:0] prev_dat;
  logic prev_vld = 1'b0;
  logic prev_rdy = 1'b0;

  // Expected beats for `count` beats of a run whose final beat index is total-1.
  task automatic push_run(input int run, input int count, input int total);
    for (int k = 0; k < count; k++) begin
      sb_e.dat  = exp_word(run, k);
      sb_e.last = (k == total - 1);
      sb.push_back(sb_e);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (prev_vld && !prev_rdy) begin
        check("hold_vld", out_vld, 1);
        check("hold_dat", out_dat, prev_dat);
      end
      if (done) done_cnt++;
      if (out_vld && out_rdy) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got %0h expected no beat", out_dat);
        end else begin
          sb_e = sb.pop_front();
          check("beat_dat", out_dat, sb_e.dat);
          check("beat_last", out_last, sb_e.last);
        end
      end
      prev_vld = out_vld;
      prev_rdy = out_rdy;
      prev_dat = out_dat;
    end
  end

  int nA[P], nB[P], dA[P], dB[P];

  task automatic set_lanes(input int n, input int d);
    for (int i = 0; i < P; i++) begin
      nA[i] = n; nB[i] = n; dA[i] = d; dB[i] = d;
    end
  endtask

  // Per-lane streams; called and returns just after a rising edge.
  task automatic drive(input int run, output int stalls, output bit tmo);
    int ia[P], ib[P];
    int c;
    bit active;
    c = 0; stalls = 0; tmo = 1'b0;
    for (int i = 0; i < P; i++) begin ia[i] = 0; ib[i] = 0; end
    forever begin
      active = 1'b0;
      for (int i = 0; i < P; i++) begin
        in_vld_A[i] = (c >= dA[i]) && (ia[i] < nA[i]);
        in_vld_B[i] = (c >= dB[i]) && (ib[i] < nB[i]);
        in_dat_A[DW*i +: DW] = a_smp(run, i, ia[i]);
        in_dat_B[DW*i +: DW] = b_smp(run, i, ib[i]);
        if (ia[i] < nA[i] || ib[i] < nB[i]) active = 1'b1;
      end
      if (!active) break;
      if (c >= 300) begin tmo = 1'b1; break; end
      @(negedge clk);
      if (rst) break;
      if ((|in_vld_A && !in_rdy_A) || (|in_vld_B && !in_rdy_B)) stalls++;
      for (int i = 0; i < P; i++) begin
        if (in_vld_A[i] && in_rdy_A) ia[i]++;
        if (in_vld_B[i] && in_rdy_B) ib[i]++;
      end
      @(posedge clk); #1;
      c++;
    end
    in_vld_A = '0;
    in_vld_B = '0;
  endtask

  task automatic start_run(input int len);
    length = 16'(len);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 500) begin @(posedge clk); n++; end
    check({name, "_done_seen"}, done_cnt > d0, 1);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_idle_busy"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdyA"}, in_rdy_A, 0);
    check({tag, "_rdyB"}, in_rdy_B, 0);
    check({tag, "_vld"}, out_vld, 0);
    check({tag, "_dat"}, out_dat, '0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err_extra, 0);
  endtask

  int  st, d0, n;
  bit  tmo, sawA, sawB;

  initial begin
    rst = 1'b1; start = 1'b0; length = '0; out_rdy = 1'b1;
    in_vld_A = '0; in_vld_B = '0; in_dat_A = '0; in_dat_B = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Case 1: aligned lanes, four consecutive beats
    set_lanes(4, 0);
    push_run(1, 4, 4);
    hs_cyc.delete();
    d0 = done_cnt;
    start_run(4);
    check("c1_busy", busy, 1);
    drive(1, st, tmo);
    check("c1_timeout", tmo, 0);
    check("c1_stalls", st, 0);
    wait_done(d0, "c1");
    check("c1_beats", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) check("c1_back_to_back", hs_cyc[3] - hs_cyc[0], 3);

    // Case 2: lane 3 five cycles late on both ports
    set_lanes(4, 0);
    dA[3] = 5; dB[3] = 5;
    push_run(1, 4, 4);
    d0 = done_cnt;
    start_run(4);
    drive(1, st, tmo);
    check("c2_timeout", tmo, 0);
    check("c2_no_backpressure", st, 0);
    wait_done(d0, "c2");

    // Case 5: lane 1 real port offers a fifth sample while others lag
    set_lanes(4, 2);
    nA[1] = 5; dA[1] = 0;
    push_run(5, 4, 4);
    d0 = done_cnt;
    start_run(4);
    check("c5_err_clear_at_start", err_extra, 0);
    drive(5, st, tmo);
    check("c5_timeout", tmo, 0);
    wait_done(d0, "c5");
    check("c5_err_sticky", err_extra, 1);

    // Case 3: downstream stall for 20 cycles with a 16-beat run
    set_lanes(16, 0);
    push_run(3, 16, 16);
    d0 = done_cnt;
    sawA = 1'b0; sawB = 1'b0;
    start_run(16);
    check("c3_err_cleared", err_extra, 0);
    fork
      drive(3, st, tmo);
      begin
        repeat (3) @(posedge clk);
        #1 out_rdy = 1'b0;
        repeat (20) begin
          @(negedge clk);
          if (!in_rdy_A) sawA = 1'b1;
          if (!in_rdy_B) sawB = 1'b1;
        end
        check("c3_vld_held", out_vld, 1);
        @(posedge clk); #1;
        out_rdy = 1'b1;
      end
    join
    check("c3_timeout", tmo, 0);
    check("c3_rdyA_dropped", sawA, 1);
    check("c3_rdyB_dropped", sawB, 1);
    wait_done(d0, "c3");

    // Case 4: zero-length run goes straight to DONE
    d0 = done_cnt;
    start_run(0);
    @(negedge clk);
    check("c4_done_pulse", done, 1);
    check("c4_busy", busy, 0);
    check("c4_vld", out_vld, 0);
    @(negedge clk);
    check("c4_done_drop", done, 0);
    check("c4_busy2", busy, 0);
    @(posedge clk); #1;
    check("c4_done_count", done_cnt - d0, 1);

    // Case 6: reset after second beat of an 8-beat run, then a fresh 2-beat run
    set_lanes(8, 0);
    push_run(6, 2, 8);
    hs_cyc.delete();
    start_run(8);
    fork
      drive(6, st, tmo);
      begin
        n = 0;
        while (hs_cyc.size() < 2 && n < 200) begin @(posedge clk); #1; n++; end
        check("c6_two_beats_seen", hs_cyc.size(), 2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("c6_rst");
        check("c6_sb_drained", sb.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    @(posedge clk); #1;
    set_lanes(2, 0);
    push_run(7, 2, 2);
    hs_cyc.delete();
    d0 = done_cnt;
    start_run(2);
    drive(7, st, tmo);
    check("c6_timeout", tmo, 0);
    wait_done(d0, "c6");
    check("c6_beats", hs_cyc.size(), 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
